bsg_dmc_ui_mux: RTL

- N-port front end for the DMC user (app_*) interface. Lets num_ports_p independent clients share one controller.
- Arbitrates commands round-robin and streams the granted client's write burst.
- Tags every accepted read so returning read bursts are steered back to the issuing port.
- Sits in the ui_clk domain, between client logic and the controller's app_* ports.

---
 rtl/bsg_dmc_pkg.sv | 20 ++
 rtl/bsg_dmc_ui_rr_arb.sv | 30 +++
 rtl/bsg_dmc_ui_mux.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/bsg_dmc_pkg.sv
// Shared types for the DMC user-interface blocks: controller command encoding,
// UI mux FSM states and a small width helper.
package bsg_dmc_pkg;

    typedef enum logic [2:0] {
        WRITE = 3'b000,
        READ  = 3'b001
    } app_cmd_e;

    typedef enum logic {
        IDLE  = 1'b0,
        WDATA = 1'b1
    } bsg_dmc_ui_mux_state_e;

    // Index width that stays at least one bit wide for single-entry ranges.
    function automatic int unsigned max1_clog2(input int unsigned value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/bsg_dmc_ui_rr_arb.sv
// Combinational round-robin arbiter: the first set request at or above the
// pointer wins, wrapping around to port 0.
module bsg_dmc_ui_rr_arb #(
    parameter int width_p    = 2,
    parameter int id_width_p = 1
) (
    input  logic [width_p-1:0]    req,
    input  logic [id_width_p-1:0] ptr,
    output logic [width_p-1:0]    grant_oh,
    output logic [id_width_p-1:0] grant_id,
    output logic                  grant_v
);

    always_comb begin
        int idx;
        idx      = 0;
        grant_oh = '0;
        grant_id = '0;
        grant_v  = 1'b0;
        for (int off = 0; off < width_p; off++) begin
            idx = (int'(ptr) + off) % width_p;
            if (!grant_v && req[idx]) begin
                grant_v       = 1'b1;
                grant_id      = id_width_p'(idx);
                grant_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_dmc_ui_mux.sv
// N-port front end for the DMC app_* interface: round-robin command arbitration,
// write-burst streaming from the granted port, and read-return steering via a tag FIFO.
module bsg_dmc_ui_mux
    import bsg_dmc_pkg::*;
#(
    parameter int num_ports_p        = 2,
    parameter int ui_addr_width_p    = 28,
    parameter int ui_data_width_p    = 32,
    parameter int burst_data_width_p = 128,
    parameter int rd_tag_depth_p     = 8,
    localparam int ui_mask_width_lp  = ui_data_width_p / 8
) (
    input  logic                                            ui_clk_i,
    input  logic                                            ui_reset_n_i,
    input  logic                                            refresh_in_progress_i,

    input  logic [num_ports_p-1:0]                          port_cmd_v_i,
    input  logic [num_ports_p-1:0][2:0]                     port_cmd_i,
    input  logic [num_ports_p-1:0][ui_addr_width_p-1:0]     port_addr_i,
    output logic [num_ports_p-1:0]                          port_cmd_ready_o,

    input  logic [num_ports_p-1:0]                          port_wdata_v_i,
    input  logic [num_ports_p-1:0][ui_data_width_p-1:0]     port_wdata_i,
    input  logic [num_ports_p-1:0][ui_mask_width_lp-1:0]    port_wmask_i,
    output logic [num_ports_p-1:0]                          port_wdata_ready_o,

    output logic [num_ports_p-1:0]                          port_rd_v_o,
    output logic [ui_data_width_p-1:0]                      port_rd_data_o,
    output logic                                            port_rd_last_o,

    output logic                                            app_en_o,
    output logic [2:0]                                      app_cmd_o,
    output logic [ui_addr_width_p-1:0]                      app_addr_o,
    input  logic                                            app_rdy_i,

    output logic                                            app_wdf_wren_o,
    output logic [ui_data_width_p-1:0]                      app_wdf_data_o,
    output logic [ui_mask_width_lp-1:0]                     app_wdf_mask_o,
    output logic                                            app_wdf_end_o,
    input  logic                                            app_wdf_rdy_i,

    input  logic                                            app_rd_data_valid_i,
    input  logic [ui_data_width_p-1:0]                      app_rd_data_i,
    input  logic                                            app_rd_data_end_i
);

    localparam int beats_lp          = burst_data_width_p / ui_data_width_p;
    localparam int port_id_width_lp  = max1_clog2(num_ports_p);
    localparam int beat_cnt_width_lp = max1_clog2(beats_lp);
    localparam int tag_addr_width_lp = max1_clog2(rd_tag_depth_p);
    localparam int tag_ptr_width_lp  = tag_addr_width_lp + 1;
    localparam int tag_slots_lp      = 1 << tag_addr_width_lp;

    bsg_dmc_ui_mux_state_e               state_r;
    logic                                live_r;
    logic [port_id_width_lp-1:0]         rr_ptr_r;
    logic [port_id_width_lp-1:0]         wr_port_r;
    logic [beat_cnt_width_lp-1:0]        beat_cnt_r;

    logic [port_id_width_lp-1:0]         tag_mem_r [tag_slots_lp];
    logic [tag_ptr_width_lp-1:0]         tag_wptr_r;
    logic [tag_ptr_width_lp-1:0]         tag_rptr_r;
    logic [tag_ptr_width_lp-1:0]         tag_used;
    logic                                tag_full;
    logic                                tag_empty;
    logic                                tag_push;
    logic                                tag_pop;
    logic [port_id_width_lp-1:0]         rd_head;
    logic                                rd_hit;

    logic [num_ports_p-1:0]              cmd_eligible;
    logic [num_ports_p-1:0]              grant_oh;
    logic [port_id_width_lp-1:0]         grant_id;
    logic                                grant_v;
    logic                                grant_write;
    logic                                handshake;
    logic [port_id_width_lp-1:0]         rr_ptr_next;

    logic                                wdata_active;
    logic                                beat_fire;

    // Outputs stay quiet until the first clock after reset release, so the
    // deassertion takes effect synchronously to ui_clk.
    assign tag_used  = tag_wptr_r - tag_rptr_r;
    assign tag_full  = (tag_used == tag_ptr_width_lp'(rd_tag_depth_p));
    assign tag_empty = (tag_used == '0);

    // Anything other than a write consumes a read tag.
    always_comb begin
        cmd_eligible = '0;
        for (int i = 0; i < num_ports_p; i++) begin
            cmd_eligible[i] = live_r && (state_r == IDLE) && port_cmd_v_i[i]
                              && !refresh_in_progress_i
                              && ((app_cmd_e'(port_cmd_i[i]) == WRITE) || !tag_full);
        end
    end

    bsg_dmc_ui_rr_arb #(
        .width_p    (num_ports_p),
        .id_width_p (port_id_width_lp)
    ) rr_arb (
        .req      (cmd_eligible),
        .ptr      (rr_ptr_r),
        .grant_oh (grant_oh),
        .grant_id (grant_id),
        .grant_v  (grant_v)
    );

    assign app_en_o         = grant_v;
    assign app_cmd_o        = port_cmd_i[grant_id];
    assign app_addr_o       = port_addr_i[grant_id];
    assign port_cmd_ready_o = grant_oh & {num_ports_p{app_rdy_i}};

    assign handshake   = app_en_o & app_rdy_i;
    assign grant_write = (app_cmd_e'(app_cmd_o) == WRITE);
    assign rr_ptr_next = (int'(grant_id) == num_ports_p - 1)
                         ? '0 : port_id_width_lp'(int'(grant_id) + 1);

    assign wdata_active   = live_r && (state_r == WDATA);
    assign app_wdf_wren_o = wdata_active && port_wdata_v_i[wr_port_r];
    assign app_wdf_data_o = port_wdata_i[wr_port_r];
    assign app_wdf_mask_o = port_wmask_i[wr_port_r];
    assign app_wdf_end_o  = wdata_active && (beat_cnt_r == beat_cnt_width_lp'(beats_lp - 1));
    assign beat_fire      = app_wdf_wren_o & app_wdf_rdy_i;

    always_comb begin
        port_wdata_ready_o = '0;
        if (wdata_active) begin
            port_wdata_ready_o[wr_port_r] = app_wdf_rdy_i;
        end
    end

    // Read beats go straight to the port at the head of the tag FIFO.
    assign rd_head = tag_mem_r[tag_rptr_r[tag_addr_width_lp-1:0]];
    assign rd_hit  = live_r && app_rd_data_valid_i && !tag_empty;
    assign tag_push = handshake && !grant_write;
    assign tag_pop  = rd_hit && app_rd_data_end_i;

    always_comb begin
        port_rd_v_o = '0;
        if (rd_hit) begin
            port_rd_v_o[rd_head] = 1'b1;
        end
    end

    assign port_rd_data_o = app_rd_data_i;
    assign port_rd_last_o = app_rd_data_end_i;

    always_ff @(posedge ui_clk_i) begin
        if (tag_push) begin
            tag_mem_r[tag_wptr_r[tag_addr_width_lp-1:0]] <= grant_id;
        end
    end

    always_ff @(posedge ui_clk_i or negedge ui_reset_n_i) begin
        if (!ui_reset_n_i) begin
            state_r    <= IDLE;
            live_r     <= 1'b0;
            rr_ptr_r   <= '0;
            wr_port_r  <= '0;
            beat_cnt_r <= '0;
            tag_wptr_r <= '0;
            tag_rptr_r <= '0;
        end else begin
            live_r <= 1'b1;
            if (tag_push) begin
                tag_wptr_r <= tag_wptr_r + 1'b1;
            end
            if (tag_pop) begin
                tag_rptr_r <= tag_rptr_r + 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (handshake) begin
                        rr_ptr_r <= rr_ptr_next;
                        if (grant_write) begin
                            wr_port_r  <= grant_id;
                            beat_cnt_r <= '0;
                            state_r    <= WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (beat_fire) begin
                        if (app_wdf_end_o) begin
                            beat_cnt_r <= '0;
                            state_r    <= IDLE;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + 1'b1;
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // A read beat with no outstanding tag means the controller broke protocol.
    assert property (@(posedge ui_clk_i) disable iff (!ui_reset_n_i)
                     !(app_rd_data_valid_i && tag_empty));

endmodule
